// File: rtl/pe_gpio_in_pkg.sv
// pe_gpio_in_pkg: shared constants and helpers for the pe_gpio_in peripheral.
//   - Register offsets (relative to the peripheral base address).
//   - Default base address of the block on the miniRV peripheral bus.
//   - Debounce FSM state encoding.
//   - popcount32: number of set bits in a 32-bit vector.
package pe_gpio_in_pkg;

  localparam logic [11:0] GPIO_IN_LEVEL   = 12'h000;
  localparam logic [11:0] GPIO_IN_RISE    = 12'h004;
  localparam logic [11:0] GPIO_IN_EVCNT   = 12'h008;
  localparam logic [11:0] GPIO_IN_FALL    = 12'h00C;
  localparam logic [11:0] PE_GPIO_IN_BASE = 12'h078;

  typedef enum logic {
    DEB_STABLE   = 1'b0,
    DEB_COUNTING = 1'b1
  } deb_state_e;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/pe_gpio_in_if.sv
// pe_gpio_in_if: peripheral bus between the Bridge and pe_gpio_in.
//   addr  [11:0] : register address (low 12 bits)
//   wen          : write enable, sampled on the clk rising edge
//   wdata [31:0] : write data
//   rdata [31:0] : combinational read data from the peripheral
// Modports: master (Bridge side), slave (peripheral side).
interface pe_gpio_in_if;
  logic [11:0] addr;
  logic        wen;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output wen, output wdata, input rdata);
  modport slave  (input addr, input wen, input wdata, output rdata);
endinterface

// File: rtl/pe_gpio_in_deb.sv
// pe_gpio_in_deb: one input channel - 2-flop synchroniser followed by a
// debounce counter/FSM and the debounced level register.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   pin         : raw asynchronous input
//   level       : debounced level
//   rise_pulse  : high in the cycle whose edge moves level 0->1
//   fall_pulse  : high in the cycle whose edge moves level 1->0
// The pulses are combinational from next-state so that registers in the
// parent update on the same edge as level.
module pe_gpio_in_deb
  import pe_gpio_in_pkg::*;
#(
  parameter int DEB_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          r_sync_p0, r_sync_p1;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  deb_state_e    r_state;

  logic          w_level_nxt;
  logic [CW-1:0] w_cnt_nxt;
  deb_state_e    w_state_nxt;

  // Stage p0/p1: metastability synchroniser
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
    end else begin
      r_sync_p0 <= pin;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // Debounce state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DEB_STABLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
    end
  end

  // The edge that first sees a difference is the first counting edge, so
  // the count starts at 1 and level flips on the DEB_CYCLES-th such edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    case (r_state)
      DEB_STABLE: begin
        w_cnt_nxt = '0;
        if (r_sync_p1 != r_level) begin
          w_state_nxt = DEB_COUNTING;
          w_cnt_nxt   = CW'(1);
        end
      end
      DEB_COUNTING: begin
        if (r_sync_p1 == r_level) begin
          w_state_nxt = DEB_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = DEB_STABLE;
          w_cnt_nxt   = '0;
          w_level_nxt = r_sync_p1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = DEB_STABLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign level      = r_level;
  assign rise_pulse = w_level_nxt & ~r_level;
  assign fall_pulse = ~w_level_nxt & r_level;

endmodule

// File: rtl/pe_gpio_in.sv
// pe_gpio_in: N-channel debounced input peripheral for the miniRV SoC.
// Registers (offset from BASE_ADDR):
//   0x0 LEVEL (RO)   debounced levels
//   0x4 RISE  (W1C)  sticky debounced 0->1 flags, set wins over clear
//   0x8 EVCNT (R/W)  saturating 16-bit count of rising edges; write zeroes
//   0xC FALL  (W1C)  sticky 1->0 flags, only with PE_GPIO_IN_FALL_EN defined
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   pin_in   : raw asynchronous inputs [N_CH-1:0]
//   bus      : pe_gpio_in_if.slave (addr, wen, wdata in; rdata out, comb.)
// Configuration macro: PE_GPIO_IN_FALL_EN (adds FALL register).
module pe_gpio_in
  import pe_gpio_in_pkg::*;
#(
  parameter int          N_CH       = 5,
  parameter int          DEB_CYCLES = 100000,
  parameter logic [11:0] BASE_ADDR  = PE_GPIO_IN_BASE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] pin_in,
  pe_gpio_in_if.slave     bus
);

  localparam logic [11:0] A_LEVEL = BASE_ADDR + GPIO_IN_LEVEL;
  localparam logic [11:0] A_RISE  = BASE_ADDR + GPIO_IN_RISE;
  localparam logic [11:0] A_EVCNT = BASE_ADDR + GPIO_IN_EVCNT;
`ifdef PE_GPIO_IN_FALL_EN
  localparam logic [11:0] A_FALL  = BASE_ADDR + GPIO_IN_FALL;
`endif

  logic [N_CH-1:0] w_level, w_rise, w_fall;
  logic [5:0]      w_pop;
  logic            w_wr_rise, w_wr_evcnt;
  logic [N_CH-1:0] r_rise;
  logic [15:0]     r_evcnt;
  logic            w_unused;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [5:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pe_gpio_in_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk        (clk),
      .rst        (rst),
      .pin        (pin_in[g]),
      .level      (w_level[g]),
      .rise_pulse (w_rise[g]),
      .fall_pulse (w_fall[g])
    );
  end

  assign w_pop      = popcount32(32'(w_rise));
  assign w_wr_rise  = bus.wen && (bus.addr == A_RISE);
  assign w_wr_evcnt = bus.wen && (bus.addr == A_EVCNT);

  // Set has priority: new rises are OR-ed in after the W1C mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rise  <= '0;
      r_evcnt <= '0;
    end else begin
      r_rise  <= (r_rise & ~(w_wr_rise ? bus.wdata[N_CH-1:0] : '0)) | w_rise;
      r_evcnt <= w_wr_evcnt ? 16'(w_pop) : sat_add16(r_evcnt, w_pop);
    end
  end

`ifdef PE_GPIO_IN_FALL_EN
  logic [N_CH-1:0] r_fall;
  logic            w_wr_fall;
  assign w_wr_fall = bus.wen && (bus.addr == A_FALL);

  always_ff @(posedge clk) begin
    if (rst) r_fall <= '0;
    else     r_fall <= (r_fall & ~(w_wr_fall ? bus.wdata[N_CH-1:0] : '0)) | w_fall;
  end
`endif

  always_comb begin
    bus.rdata = 32'h0;
    case (bus.addr)
      A_LEVEL: bus.rdata = 32'(w_level);
      A_RISE:  bus.rdata = 32'(r_rise);
      A_EVCNT: bus.rdata = {16'h0, r_evcnt};
`ifdef PE_GPIO_IN_FALL_EN
      A_FALL:  bus.rdata = 32'(r_fall);
`endif
      default: bus.rdata = 32'h0;
    endcase
  end

  // Upper write-data bits and (when FALL is disabled) fall pulses are unused.
  assign w_unused = &{1'b0, bus.wdata, w_fall};

endmodule
